// File: rtl/clock_div_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master side drives enable, divisor writes and sync; the slave side
// (the divider) returns the per-channel divided clocks and tick strobes.
interface clock_div_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    localparam int AW = $clog2(CHANNELS);

    logic                Enable;
    logic                WrEn;
    logic [AW-1:0]       WrAddr;
    logic [WIDTH-1:0]    WrData;
    logic                Sync;
    logic [CHANNELS-1:0] DividedClock;
    logic [CHANNELS-1:0] Tick;

    modport master (
        output Enable, WrEn, WrAddr, WrData, Sync,
        input  DividedClock, Tick
    );

    modport slave (
        input  Enable, WrEn, WrAddr, WrData, Sync,
        output DividedClock, Tick
    );
endinterface

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider and tick generator.
// Every channel counts up to its active divisor, then toggles its divided
// clock and pulses its tick. New divisors land in a shadow register and are
// only adopted at terminal count (or on Sync), so a half-period in progress
// always finishes with the divisor it started with.
module clock_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 50000
) (
    input logic              Clock,
    input logic              Reset,
    clock_div_multi_if.slave bus
);
    localparam int AW = $clog2(CHANNELS);

    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    div_q    [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    next_div [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] dclk_q;
    logic [CHANNELS-1:0] tick_q;

    // Decode the write per channel; a write on a reload edge bypasses the shadow.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i]   = bus.WrEn && (bus.WrAddr == AW'(i));
            next_div[i] = wr_hit[i] ? bus.WrData : shadow_q[i];
        end
    end

    // Per-channel counter, divisor reload, divided clock and tick registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]    <= '0;
                div_q[i]    <= WIDTH'(DEFAULT_DIV);
                shadow_q[i] <= WIDTH'(DEFAULT_DIV);
                dclk_q[i]   <= 1'b0;
                tick_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) begin
                    shadow_q[i] <= bus.WrData;
                end
                if (bus.Sync) begin
                    cnt_q[i]  <= '0;
                    dclk_q[i] <= 1'b0;
                    tick_q[i] <= 1'b0;
                    div_q[i]  <= next_div[i];
                end else if (bus.Enable) begin
                    if (cnt_q[i] == div_q[i]) begin
                        cnt_q[i]  <= '0;
                        dclk_q[i] <= ~dclk_q[i];
                        tick_q[i] <= 1'b1;
                        div_q[i]  <= next_div[i];
                    end else begin
                        cnt_q[i]  <= cnt_q[i] + WIDTH'(1);
                        tick_q[i] <= 1'b0;
                    end
                end else begin
                    tick_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.DividedClock = dclk_q;
    assign bus.Tick         = tick_q;
endmodule
